// File: rtl/word_addr_decode_stage.sv
// ---------------------------------------------------------------------------
// word_addr_decode_stage
//
// Turns a byte address coming out of EX/MEM into the word index used by the
// word-addressed memories. The address is checked for word alignment when the
// beat is accepted. A misaligned beat is swallowed, its address is recorded and
// a sticky fault blocks intake until the exception unit acknowledges it.
// The stage is one register deep, with a one-entry skid buffer behind it, so
// that it can run at full throughput with a registered in_ready.
//
// Handshake: a beat moves on an interface in a cycle where valid and ready are
// both high at the rising clock edge. A producer holding valid high keeps its
// payload stable until the beat moves. This stage keeps out_* stable while
// out_valid=1 and out_ready=0. in_ready never depends on in_valid in the same
// cycle, because it is a register.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   flush          synchronous flush: drops buffered beats and clears the fault
//   in_valid       upstream beat valid
//   in_ready       stage can accept a beat (registered)
//   in_byte_addr   byte address of the beat
//   in_is_write    access type, carried with the beat
//   out_valid      downstream beat valid
//   out_ready      downstream accepts
//   out_word_addr  in_byte_addr[ADDR_W-1:2] of the beat
//   out_is_write   access type of the beat
//   fault          misalignment fault pending
//   fault_addr     full byte address of the last faulting beat
//   fault_ack      clears a pending fault
//   fault_count    faults since reset, saturating
//   fsm_state      debug view of the control FSM (0 = RUN, 1 = FAULT)
// ---------------------------------------------------------------------------
module word_addr_decode_stage #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_byte_addr,
    input  logic              in_is_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-3:0] out_word_addr,
    output logic              out_is_write,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr,
    input  logic              fault_ack,
    output logic [CNT_W-1:0]  fault_count,
    output logic              fsm_state
);

    localparam int WORD_W = ADDR_W - 2;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_word_q, out_word_d;
    logic              out_wr_q, out_wr_d;
    logic              skid_valid_q, skid_valid_d;
    logic [WORD_W-1:0] skid_word_q, skid_word_d;
    logic              skid_wr_q, skid_wr_d;
    logic [ADDR_W-1:0] fault_addr_q;
    logic [CNT_W-1:0]  fault_count_q;

    logic accept;
    logic misaligned;
    logic take_good;
    logic take_bad;
    logic out_free;

    // A beat offered during a flush is dropped, so flush gates acceptance.
    assign accept     = in_valid && in_ready_q && !flush;
    assign misaligned = (in_byte_addr[1:0] != 2'b00);
    assign take_good  = accept && !misaligned;
    assign take_bad   = accept && misaligned;
    // The output register can be loaded when it is empty or retiring this cycle.
    assign out_free   = !out_valid_q || out_ready;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        out_wr_d     = out_wr_q;
        skid_valid_d = skid_valid_q;
        skid_word_d  = skid_word_q;
        skid_wr_d    = skid_wr_q;

        if (flush) begin
            state_d      = RUN;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case (state_q)
                RUN:     if (take_bad)  state_d = FAULT;
                FAULT:   if (fault_ack) state_d = RUN;
                default: state_d = RUN;
            endcase

            // in_ready_q=1 guarantees the skid is empty, so an accepted beat
            // and a skid drain never compete for the output register.
            if (out_free) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_word_d   = skid_word_q;
                    out_wr_d     = skid_wr_q;
                    skid_valid_d = 1'b0;
                end else if (take_good) begin
                    out_valid_d = 1'b1;
                    out_word_d  = in_byte_addr[ADDR_W-1:2];
                    out_wr_d    = in_is_write;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (take_good) begin
                skid_valid_d = 1'b1;
                skid_word_d  = in_byte_addr[ADDR_W-1:2];
                skid_wr_d    = in_is_write;
            end
        end

        // Registered ready: look at where state and skid are heading.
        in_ready_d = (state_d == RUN) && !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            out_wr_q     <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_word_q  <= '0;
            skid_wr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            out_wr_q     <= out_wr_d;
            skid_valid_q <= skid_valid_d;
            skid_word_q  <= skid_word_d;
            skid_wr_q    <= skid_wr_d;
        end
    end

    // Fault record survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_addr_q  <= '0;
            fault_count_q <= '0;
        end else if (take_bad) begin
            fault_addr_q <= in_byte_addr;
            if (fault_count_q != CNT_MAX) begin
                fault_count_q <= fault_count_q + CNT_ONE;
            end
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_word_addr = out_word_q;
    assign out_is_write  = out_wr_q;
    assign fault         = (state_q == FAULT);
    assign fault_addr    = fault_addr_q;
    assign fault_count   = fault_count_q;
    assign fsm_state     = (state_q == FAULT);

endmodule

// File: tb/tb_word_addr_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_word_addr_decode_stage
//
// Directed bench for word_addr_decode_stage (ADDR_W=32, CNT_W=8). Inputs are
// driven 1 time unit after a rising edge and outputs are checked 1 time unit
// after the following rising edge. Expected values are worked out by hand.
// ---------------------------------------------------------------------------
module tb_word_addr_decode_stage;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_byte_addr;
  logic              in_is_write;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-3:0] out_word_addr;
  logic              out_is_write;
  logic              fault;
  logic [ADDR_W-1:0] fault_addr;
  logic              fault_ack;
  logic [CNT_W-1:0]  fault_count;
  logic              fsm_state;

  int n_assert;
  int n_fail;

  word_addr_decode_stage #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_byte_addr (in_byte_addr),
    .in_is_write  (in_is_write),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word_addr(out_word_addr),
    .out_is_write (out_is_write),
    .fault        (fault),
    .fault_addr   (fault_addr),
    .fault_ack    (fault_ack),
    .fault_count  (fault_count),
    .fsm_state    (fsm_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [29:0] wa, input logic wr);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    if (v) begin
      chk({tag, ".out_word_addr"}, 64'(out_word_addr), 64'(wa));
      chk({tag, ".out_is_write"}, 64'(out_is_write), 64'(wr));
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic wr);
    in_valid     = v;
    in_byte_addr = a;
    in_is_write  = wr;
  endtask

  logic [CNT_W-1:0] exp_cnt;

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    flush     = 1'b0;
    fault_ack = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0);

    // ---- reset ----
    #1 rst_n = 1'b0;
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_word_addr", 64'(out_word_addr), 64'd0);
    chk("rst.out_is_write", 64'(out_is_write), 64'd0);
    chk("rst.fault", 64'(fault), 64'd0);
    chk("rst.fault_addr", 64'(fault_addr), 64'd0);
    chk("rst.fault_count", 64'(fault_count), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    chk("rel.in_ready_before_edge", 64'(in_ready), 64'd0);
    step();
    chk("rel.in_ready", 64'(in_ready), 64'd1);
    chk("rel.out_valid", 64'(out_valid), 64'd0);

    // ---- 1: back-to-back stream ----
    drive(1'b1, 32'h0000_1000, 1'b0);
    step();
    chk_out("t1.b0", 1'b1, 30'h400, 1'b0);
    chk("t1.b0.in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h0000_1004, 1'b1);
    step();
    chk_out("t1.b1", 1'b1, 30'h401, 1'b1);
    drive(1'b1, 32'h0000_1008, 1'b0);
    step();
    chk_out("t1.b2", 1'b1, 30'h402, 1'b0);
    chk("t1.b2.in_ready", 64'(in_ready), 64'd1);
    drive(1'b0, 32'h0, 1'b0);
    step();
    chk_out("t1.idle", 1'b0, 30'h0, 1'b0);

    // ---- 2: stall fills the skid, order preserved ----
    drive(1'b1, 32'h0000_1010, 1'b1);
    step();
    chk_out("t2.a", 1'b1, 30'h404, 1'b1);
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_1014, 1'b0);
    step();
    chk_out("t2.stall1", 1'b1, 30'h404, 1'b1);
    chk("t2.stall1.in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h0000_1018, 1'b1);
    step();
    chk_out("t2.stall2", 1'b1, 30'h404, 1'b1);
    chk("t2.stall2.in_ready", 64'(in_ready), 64'd0);
    step();
    chk_out("t2.stall3", 1'b1, 30'h404, 1'b1);
    out_ready = 1'b1;
    step();
    chk_out("t2.skid_drain", 1'b1, 30'h405, 1'b0);
    chk("t2.skid_drain.in_ready", 64'(in_ready), 64'd1);
    step();
    chk_out("t2.c", 1'b1, 30'h406, 1'b1);
    drive(1'b0, 32'h0, 1'b0);
    step();
    chk_out("t2.idle", 1'b0, 30'h0, 1'b0);

    // ---- 3: misaligned beat behind two buffered beats ----
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_3000, 1'b0);
    step();
    chk_out("t3.a", 1'b1, 30'hC00, 1'b0);
    drive(1'b1, 32'h0000_3004, 1'b1);
    step();
    chk("t3.skid.in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h0000_2002, 1'b0);
    step();
    chk_out("t3.hold", 1'b1, 30'hC00, 1'b0);
    chk("t3.hold.fault", 64'(fault), 64'd0);
    out_ready = 1'b1;
    step();
    chk_out("t3.drain_b", 1'b1, 30'hC01, 1'b1);
    chk("t3.drain_b.fault", 64'(fault), 64'd0);
    step();
    drive(1'b0, 32'h0, 1'b0);
    chk_out("t3.not_fwd", 1'b0, 30'h0, 1'b0);
    chk("t3.fault", 64'(fault), 64'd1);
    chk("t3.fault_addr", 64'(fault_addr), 64'h0000_2002);
    chk("t3.fault_count", 64'(fault_count), 64'd1);
    chk("t3.in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h0000_4000, 1'b0);
    step();
    chk("t3.blocked.in_ready", 64'(in_ready), 64'd0);
    chk_out("t3.blocked", 1'b0, 30'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    fault_ack = 1'b1;
    step();
    fault_ack = 1'b0;
    chk("t3.ack.fault", 64'(fault), 64'd0);
    chk("t3.ack.in_ready", 64'(in_ready), 64'd1);
    chk("t3.ack.fault_addr", 64'(fault_addr), 64'h0000_2002);

    // ---- 5: flush with fault pending and output full ----
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_5000, 1'b0);
    step();
    chk_out("t5.a", 1'b1, 30'h1400, 1'b0);
    drive(1'b1, 32'h0000_5001, 1'b0);
    step();
    chk("t5.fault", 64'(fault), 64'd1);
    chk("t5.fault_count", 64'(fault_count), 64'd2);
    chk("t5.fault_addr", 64'(fault_addr), 64'h0000_5001);
    chk_out("t5.held", 1'b1, 30'h1400, 1'b0);
    flush     = 1'b1;
    fault_ack = 1'b1;
    drive(1'b1, 32'h0000_6000, 1'b0);
    step();
    flush     = 1'b0;
    fault_ack = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    chk("t5.flush.out_valid", 64'(out_valid), 64'd0);
    chk("t5.flush.fault", 64'(fault), 64'd0);
    chk("t5.flush.in_ready", 64'(in_ready), 64'd1);
    chk("t5.flush.fault_count", 64'(fault_count), 64'd2);
    chk("t5.flush.fault_addr", 64'(fault_addr), 64'h0000_5001);
    out_ready = 1'b1;
    step();
    chk("t5.dropped.out_valid", 64'(out_valid), 64'd0);
    // flush with the skid full
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_7000, 1'b0);
    step();
    drive(1'b1, 32'h0000_7004, 1'b0);
    step();
    chk("t5.skid.in_ready", 64'(in_ready), 64'd0);
    drive(1'b0, 32'h0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5.flush2.out_valid", 64'(out_valid), 64'd0);
    chk("t5.flush2.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    chk("t5.flush2.no_ghost", 64'(out_valid), 64'd0);

    // ---- ack while running is ignored ----
    fault_ack = 1'b1;
    step();
    fault_ack = 1'b0;
    chk("ack_run.fault", 64'(fault), 64'd0);
    chk("ack_run.in_ready", 64'(in_ready), 64'd1);

    // ---- 4: fault counter saturates ----
    exp_cnt = 8'd2;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 32'h0001_0000 + 32'(i * 4) + 32'd3, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0);
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      chk("t4.fault_count", 64'(fault_count), 64'(exp_cnt));
      chk("t4.fault", 64'(fault), 64'd1);
      fault_ack = 1'b1;
      step();
      fault_ack = 1'b0;
    end
    chk("t4.sat", 64'(fault_count), 64'd255);
    chk("t4.last_addr", 64'(fault_addr), 64'h0001_03FF);
    chk("t4.in_ready", 64'(in_ready), 64'd1);

    // ---- 6: asynchronous reset mid-stream ----
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_8000, 1'b1);
    step();
    drive(1'b1, 32'h0000_8004, 1'b0);
    step();
    chk_out("t6.pre", 1'b1, 30'h2000, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6.rst.out_valid", 64'(out_valid), 64'd0);
    chk("t6.rst.in_ready", 64'(in_ready), 64'd0);
    chk("t6.rst.out_word_addr", 64'(out_word_addr), 64'd0);
    chk("t6.rst.out_is_write", 64'(out_is_write), 64'd0);
    chk("t6.rst.fault_count", 64'(fault_count), 64'd0);
    chk("t6.rst.fault_addr", 64'(fault_addr), 64'd0);
    drive(1'b0, 32'h0, 1'b0);
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("t6.rel.in_ready", 64'(in_ready), 64'd1);
    chk("t6.rel.out_valid", 64'(out_valid), 64'd0);
    step();
    chk("t6.rel.quiet", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h0000_9000, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0);
    chk_out("t6.new", 1'b1, 30'h2400, 1'b1);
    step();
    chk_out("t6.after", 1'b0, 30'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
